pc_fetch_unit: RTL



---
 rtl/cpu_pkg.sv | 15 +
 rtl/pc_fetch_unit_if.sv | 30 +++
 rtl/pc_next_sel.sv | 44 ++++
 rtl/pc_fetch_unit.sv | 88 ++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: default widths, vectors and the fetch FSM encoding.
package cpu_pkg;

   localparam int          XLEN_DEFAULT         = 32;
   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] TRAP_VECTOR_DEFAULT  = 32'h0000_0100;
   localparam int          STEP_DEFAULT         = 4;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit control and imem request bundle; the fetch unit is the master side.
interface pc_fetch_unit_if
   import cpu_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
);

   logic            stall;
   logic            branch;
   logic [XLEN-1:0] branch_target;
   logic            trap;
   logic            halt;
   logic            resume;
   logic            fetch_ready;
   logic            fetch_valid;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus_step;
   logic            misaligned;

   modport master (
      input  stall, branch, branch_target, trap, halt, resume, fetch_ready,
      output fetch_valid, pc, pc_plus_step, misaligned
   );

   modport slave (
      output stall, branch, branch_target, trap, halt, resume, fetch_ready,
      input  fetch_valid, pc, pc_plus_step, misaligned
   );

endinterface

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: trap, then branch (aligned or misaligned), then sequential advance.
module pc_next_sel
   import cpu_pkg::*;
#(
   parameter int              XLEN        = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(TRAP_VECTOR_DEFAULT),
   parameter int              STEP        = STEP_DEFAULT
) (
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] pc_plus_step_i,
   input  logic [XLEN-1:0] branch_target_i,
   input  logic            trap_i,
   input  logic            branch_i,
   input  logic            in_run_i,
   input  logic            accept_i,
   output logic [XLEN-1:0] pc_next_o,
   output logic            misaligned_o
);

   localparam int ALIGN_BITS = $clog2(STEP);

   logic target_misaligned;

   assign target_misaligned = |branch_target_i[ALIGN_BITS-1:0];

   always_comb begin
      pc_next_o    = pc_i;
      misaligned_o = 1'b0;
      if (trap_i) begin
         pc_next_o = TRAP_VECTOR;
      end else if (branch_i && in_run_i) begin
         // A bad target is turned into a trap redirect rather than fetched.
         if (target_misaligned) begin
            pc_next_o    = TRAP_VECTOR;
            misaligned_o = 1'b1;
         end else begin
            pc_next_o = branch_target_i;
         end
      end else if (accept_i) begin
         pc_next_o = pc_plus_step_i;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter: BOOT/RUN/HALTED sequencing, imem request handshake and redirects.
module pc_fetch_unit
   import cpu_pkg::*;
#(
   parameter int              XLEN         = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEFAULT),
   parameter int              STEP         = STEP_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   pc_fetch_unit_if.master  bus
);

   localparam logic [XLEN-1:0] STEP_W = XLEN'(STEP);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_plus_step;
   logic            misaligned_q, misaligned_d;
   logic            fetch_valid;
   logic            in_run;
   logic            accept;

   assign pc_plus_step = pc_q + STEP_W;
   assign accept       = fetch_valid && bus.fetch_ready && !bus.stall;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   // halt is only honoured from RUN, so BOOT always completes its single cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT:    state_d = RUN;
         RUN:     if (bus.halt) state_d = HALTED;
         HALTED:  if (bus.resume || bus.trap) state_d = RUN;
         default: state_d = BOOT;
      endcase
   end

   always_comb begin
      fetch_valid = 1'b0;
      in_run      = 1'b0;
      if (state_q == RUN) begin
         fetch_valid = 1'b1;
         in_run      = 1'b1;
      end
   end

   pc_next_sel #(
      .XLEN        (XLEN),
      .TRAP_VECTOR (TRAP_VECTOR),
      .STEP        (STEP)
   ) u_pc_next_sel (
      .pc_i            (pc_q),
      .pc_plus_step_i  (pc_plus_step),
      .branch_target_i (bus.branch_target),
      .trap_i          (bus.trap),
      .branch_i        (bus.branch),
      .in_run_i        (in_run),
      .accept_i        (accept),
      .pc_next_o       (pc_d),
      .misaligned_o    (misaligned_d)
   );

   // Reset clears the pending pulse as well, so no stale misaligned survives it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q         <= RESET_VECTOR;
         misaligned_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign bus.fetch_valid  = fetch_valid;
   assign bus.pc           = pc_q;
   assign bus.pc_plus_step = pc_plus_step;
   assign bus.misaligned   = misaligned_q;

endmodule
